// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg : op encodings and result record for the alu_pipe datapath. Rev 1.0
// ----------------------------------------------------------------------------
package alu_pkg;

    // Upper bound on WIDTH; result records carry out zero-extended to this size.
    localparam int ALU_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_SHL    = 3'd5,
        OP_SHR    = 3'd6,
        OP_PASS_A = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                 c;
        logic                 zero;
        logic                 ovf;
        logic [ALU_MAX_W-1:0] out;
    } alu_res_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe_if : valid/ready input and output channels of alu_pipe. Rev 1.0
// ----------------------------------------------------------------------------
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    alu_op_e          op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             c;
    logic             zero;
    logic             ovf;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, operand_a, operand_b, op, out_ready,
        input  in_ready, out_valid, out, c, zero, ovf, op_count
    );

    modport slave (
        input  in_valid, operand_a, operand_b, op, out_ready,
        output in_ready, out_valid, out, c, zero, ovf, op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe_core : combinational 8-op ALU producing result and flags. Rev 1.0
// ----------------------------------------------------------------------------
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output alu_res_t         res
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] r;
    logic             cf;
    logic             of;

    assign sh   = b[SH_W-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // One guard bit on either side captures the last bit shifted out, and
    // naturally yields 0 for a zero shift or a shift past the operand.
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;

    always_comb begin
        r  = '0;
        cf = 1'b0;
        of = 1'b0;
        case (op)
            OP_ADD: begin
                r  = sum[WIDTH-1:0];
                cf = sum[WIDTH];
                of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r  = diff[WIDTH-1:0];
                cf = diff[WIDTH];
                of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_SHL: begin
                r  = shl_ext[WIDTH-1:0];
                cf = shl_ext[WIDTH];
            end
            OP_SHR: begin
                r  = shr_ext[WIDTH:1];
                cf = shr_ext[0];
            end
            OP_PASS_A: r = a;
            default:   r = a;
        endcase
    end

    always_comb begin
        res              = '0;
        res.out[WIDTH-1:0] = r;
        res.c            = cf;
        res.ovf          = of;
        res.zero         = (r == '0);
    end
endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe : two-stage elastic ALU pipeline with saturating op counter. Rev 1.0
// ----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_out;
    logic             s2_c;
    logic             s2_zero;
    logic             s2_ovf;

    logic [CNT_W-1:0] cnt;
    logic             s1_adv;
    logic             s2_adv;
    alu_res_t         res;

    // A stage may load whenever it is empty or its contents move on this edge.
    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (s1_a),
        .b   (s1_b),
        .op  (s1_op),
        .res (res)
    );

    generate
        if (WIDTH < ALU_MAX_W) begin : g_unused_hi
            logic unused_res_hi;
            assign unused_res_hi = ^res.out[ALU_MAX_W-1:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_c     <= 1'b0;
            s2_zero  <= 1'b0;
            s2_ovf   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a  <= bus.operand_a;
                    s1_b  <= bus.operand_b;
                    s1_op <= bus.op;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_out  <= res.out[WIDTH-1:0];
                    s2_c    <= res.c;
                    s2_zero <= res.zero;
                    s2_ovf  <= res.ovf;
                end
            end
            if (s2_valid && bus.out_ready && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_out;
    assign bus.c         = s2_c;
    assign bus.zero      = s2_zero;
    assign bus.ovf       = s2_ovf;
    assign bus.op_count  = cnt;

    a_op_known : assert property (@(posedge clk) disable iff (!rst_n)
        bus.in_valid |-> !$isunknown(bus.op));
endmodule
`default_nettype wire
